// File: rtl/fpga_top_adder_pkg.sv
// Shared width, word type and golden add function for the fpga_top_adder block.
// No logic of its own; ref_add gives the WIDTH+1 bit unsigned result of a+b+cin.
package fpga_top_adder_pkg;

    localparam int ADDER_WIDTH = 32;

    typedef logic [ADDER_WIDTH-1:0] word_t;

    function automatic logic [ADDER_WIDTH:0] ref_add(input word_t x, input word_t y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {{ADDER_WIDTH{1'b0}}, ci};
    endfunction

endpackage

// File: rtl/fpga_top_adder_cell.sv
// One-bit full-adder cell, a link in the ripple-carry chain.
// Combinational, 0 cycles; no flow control.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/fpga_top_adder.sv
// Ripple-carry adder {cout,sum} = a+b+cin; 0 cycles, or 1 cycle with FPGA_TOP_ADDER_OUTPUT_REG_EN.
// No backpressure; clk/global_resetn only matter when FPGA_TOP_ADDER_OUTPUT_REG_EN is defined.
import fpga_top_adder_pkg::*;

module fpga_top_adder #(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             global_resetn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_c[i]),
            .s  (w_s[i]),
            .co (w_c[i+1])
        );
    end

`ifdef FPGA_TOP_ADDER_OUTPUT_REG_EN
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    // Reset has priority over the freshly computed result.
    always_ff @(posedge clk) begin
        if (!global_resetn) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_c[WIDTH];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
`else
    // Pins kept for a stable pinout; they drive nothing here.
    logic w_unused;
    assign w_unused = clk & global_resetn;

    assign sum  = w_s;
    assign cout = w_c[WIDTH];
`endif

endmodule

// File: tb/tb_fpga_top_adder.sv
// Scoreboard bench for fpga_top_adder, default and registered-output builds.
import fpga_top_adder_pkg::*;

module tb_fpga_top_adder;

    logic        clk = 1'b0;
    logic        global_resetn;
    word_t       a, b;
    logic        cin;
    word_t       sum;
    logic        cout;

    int n_total = 0;
    int n_bad   = 0;
    logic [ADDER_WIDTH:0] exp_q[$];

    always #5 clk = ~clk;

    fpga_top_adder #(.WIDTH(ADDER_WIDTH)) dut (
        .clk           (clk),
        .global_resetn (global_resetn),
        .a             (a),
        .b             (b),
        .cin           (cin),
        .sum           (sum),
        .cout          (cout)
    );

    task automatic chk(input string tag, input logic [ADDER_WIDTH:0] got, input logic [ADDER_WIDTH:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {cout,sum}=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
`ifdef FPGA_TOP_ADDER_OUTPUT_REG_EN
        @(posedge clk);
        #1;
`else
        #2;
`endif
    endtask

    task automatic pop_chk(input string tag);
        logic [ADDER_WIDTH:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h", tag, {cout, sum});
        end else begin
            e = exp_q.pop_front();
            chk(tag, {cout, sum}, e);
        end
    endtask

    task automatic vec(input string tag, input word_t va, input word_t vb, input logic vc,
                       input logic [ADDER_WIDTH:0] exp);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        exp_q.push_back(exp);
        settle();
        pop_chk(tag);
    endtask

    initial begin
        global_resetn = 1'b0;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        repeat (2) @(negedge clk);

        // Reset held low throughout random stimulus.
        for (int i = 0; i < 50; i++) begin
            word_t ra, rb;
            logic  rc;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            @(negedge clk);
            a   = ra;
            b   = rb;
            cin = rc;
`ifdef FPGA_TOP_ADDER_OUTPUT_REG_EN
            exp_q.push_back('0);
            #6;
`else
            exp_q.push_back(ref_add(ra, rb, rc));
            #4;
`endif
            pop_chk("rst_rand");
        end

`ifdef FPGA_TOP_ADDER_OUTPUT_REG_EN
        @(negedge clk);
        global_resetn = 1'b1;
        a   = 32'hFFFF_FFFF;
        b   = 32'h0;
        cin = 1'b1;
        #1;
        chk("pre_edge", {cout, sum}, '0);
        exp_q.push_back({1'b1, 32'h0});
        @(posedge clk);
        #1;
        pop_chk("first_edge");
        @(negedge clk);
        global_resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset", {cout, sum}, '0);
        @(negedge clk);
        global_resetn = 1'b1;
`else
        vec("ones_cin_rst", 32'hFFFF_FFFF, 32'h0, 1'b1, {1'b1, 32'h0});
        @(negedge clk);
        global_resetn = 1'b1;
`endif

        vec("alt_cin0",   32'hAAAA_AAAA, 32'h5555_5555, 1'b0, {1'b0, 32'hFFFF_FFFF});
        vec("alt_cin1",   32'hAAAA_AAAA, 32'h5555_5555, 1'b1, {1'b1, 32'h0000_0000});
        vec("zero_cin0",  32'h0,         32'h0,         1'b0, {1'b0, 32'h0000_0000});
        vec("zero_cin1",  32'h0,         32'h0,         1'b1, {1'b0, 32'h0000_0001});
        vec("one_one_c1", 32'h1,         32'h1,         1'b1, {1'b0, 32'h0000_0003});
        vec("a1_b0",      32'h1,         32'h0,         1'b0, {1'b0, 32'h0000_0001});
        vec("a0_b1",      32'h0,         32'h1,         1'b0, {1'b0, 32'h0000_0001});
        vec("msb_msb_c1", 32'h8000_0000, 32'h8000_0000, 1'b1, {1'b1, 32'h0000_0001});
        vec("msb_b_c1",   32'h0,         32'h8000_0000, 1'b1, {1'b0, 32'h8000_0001});
        vec("ones_cin",   32'hFFFF_FFFF, 32'h0,         1'b1, {1'b1, 32'h0000_0000});
        vec("ones_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'hFFFF_FFFF});
        vec("mid_carry",  32'h0000_FFFF, 32'h0000_0001, 1'b0, {1'b0, 32'h0001_0000});

        for (int i = 0; i < 20; i++) begin
            word_t ra, rb;
            logic  rc;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            vec("run_rand", ra, rb, rc, ref_add(ra, rb, rc));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
